// File: rtl/jhash_sched.sv
// Round-robin scheduler sharing one jhash engine between NREQ requesters.
// Optional watchdog abort of a stuck engine job: define JHASH_SCHED_TIMEOUT_EN.
module jhash_sched #(
  parameter int NREQ  = 4,
  parameter int PTRW  = 2,
  parameter int TMO_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_initval,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          result,
  output logic [NREQ-1:0]      eng_ce,
  output logic                 eng_start,
  output logic [31:0]          eng_initval,
  input  logic                 eng_done,
  input  logic [31:0]          eng_hash,
  output logic                 busy,
  output logic [NREQ-1:0]      err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_e;

  if (NREQ < 2 || NREQ > 8 || (1 << PTRW) < NREQ || TMO_W < 2) begin : g_bad_params
    $error("jhash_sched: illegal NREQ/PTRW/TMO_W combination");
  end

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PTRW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [31:0]       initval_q, initval_d;
  logic [31:0]       result_q, result_d;
  logic              eng_done_d_q;

  logic              eng_done_edge;
  logic              tmo_expired;
  logic              tmo_abort;

  logic              win_found;
  logic [PTRW-1:0]   win_idx;
  logic [NREQ-1:0]   win_oh;
  logic [31:0]       win_initval;

  // eng_done may be a level (stream_done); only a fresh rising edge completes a job.
  assign eng_done_edge = eng_done & ~eng_done_d_q;

  // Rotating priority: search pointer+1, pointer+2, ... with wrap modulo NREQ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned -- that is what keeps synthesis from inferring a latch.
    win_found   = 1'b0;
    win_idx     = '0;
    win_oh      = '0;
    win_initval = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && (i == (int'(ptr_q) + k) % NREQ) && req[i]) begin
          win_found   = 1'b1;
          win_idx     = PTRW'(i);
          win_oh[i]   = 1'b1;
          win_initval = req_initval[32*i +: 32];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    initval_d = initval_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d     = win_oh;
          gnt_idx_d = win_idx;
          initval_d = win_initval;
          state_d   = S_START;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        // A completion edge in the terminal-count cycle beats the timeout.
        if (eng_done_edge) begin
          result_d = eng_hash;
          state_d  = S_DONE;
        end else if (tmo_expired) begin
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = gnt_idx_q;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      gnt_idx_q    <= '0;
      ptr_q        <= PTRW'(NREQ - 1);
      initval_q    <= '0;
      result_q     <= '0;
      eng_done_d_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_idx_q    <= gnt_idx_d;
      ptr_q        <= ptr_d;
      initval_q    <= initval_d;
      result_q     <= result_d;
      eng_done_d_q <= eng_done;
    end
  end

`ifdef JHASH_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic             abort_q, abort_d;

  assign tmo_expired = (state_q == S_RUN) && (&tmo_q) && !eng_done_edge;

  // abort_q marks the cleanup pass through S_DONE so done stays quiet.
  always_comb begin
    tmo_d   = tmo_q;
    err_d   = err_q;
    abort_d = abort_q;
    if (state_q == S_START) begin
      tmo_d = '0;
    end else if (state_q == S_RUN) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (tmo_expired) begin
      err_d   = err_q | gnt_q;
      abort_d = 1'b1;
    end else if (state_q == S_DONE) begin
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q   <= '0;
      err_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign tmo_abort = abort_q;
  assign err       = err_q;
`else
  assign tmo_expired = 1'b0;
  assign tmo_abort   = 1'b0;
  assign err         = '0;
`endif

  assign gnt         = gnt_q;
  assign done        = (state_q == S_DONE && !tmo_abort) ? gnt_q : '0;
  assign eng_ce      = (state_q == S_START || state_q == S_RUN) ? gnt_q : '0;
  assign eng_start   = (state_q == S_START);
  assign eng_initval = initval_q;
  assign result      = result_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_jhash_sched.sv
// Directed self-checking bench for jhash_sched (NREQ=4, TMO_W=4); the engine
// side is driven by hand from the stimulus sequence.
module tb_jhash_sched;

  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [32*NREQ-1:0]  req_initval;
  logic [NREQ-1:0]     gnt, done, eng_ce, err;
  logic [31:0]         result, eng_initval, eng_hash;
  logic                eng_start, eng_done, busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ivs [4];

  jhash_sched #(.NREQ(NREQ), .PTRW(2), .TMO_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_initval (req_initval),
    .gnt         (gnt),
    .done        (done),
    .result      (result),
    .eng_ce      (eng_ce),
    .eng_start   (eng_start),
    .eng_initval (eng_initval),
    .eng_done    (eng_done),
    .eng_hash    (eng_hash),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered in S_IDLE just after an edge with req already driven; leaves in S_IDLE.
  task automatic do_job(input string tag, input logic [3:0] exp_gnt, input logic [31:0] exp_iv,
                        input logic [31:0] hash, input int run_cycles, input logic [3:0] req_after);
    step();
    check({tag, ".gnt"}, gnt, exp_gnt);
    check({tag, ".start"}, eng_start, 1);
    check({tag, ".ce_start"}, eng_ce, exp_gnt);
    check({tag, ".initval"}, eng_initval, exp_iv);
    step();
    check({tag, ".start_off"}, eng_start, 0);
    for (int i = 1; i < run_cycles; i++) begin
      check({tag, ".ce_run"}, eng_ce, exp_gnt);
      check({tag, ".done_early"}, done, 0);
      step();
    end
    eng_hash = hash;
    eng_done = 1'b1;
    step();
    check({tag, ".done"}, done, exp_gnt);
    check({tag, ".result"}, result, hash);
    check({tag, ".ce_done"}, eng_ce, 0);
    eng_done = 1'b0;
    req      = req_after;
    step();
    check({tag, ".done_clr"}, done, 0);
    check({tag, ".gnt_idle"}, gnt, 0);
    check({tag, ".busy_idle"}, busy, 0);
    check({tag, ".result_hold"}, result, hash);
  endtask

  initial begin
    ivs[0] = 32'h11111111;
    ivs[1] = 32'hDEADBEEF;
    ivs[2] = 32'h22222222;
    ivs[3] = 32'h33333333;
    req_initval = {ivs[3], ivs[2], ivs[1], ivs[0]};
    rst      = 1'b1;
    req      = '0;
    eng_done = 1'b0;
    eng_hash = '0;
    step();
    step();
    check("rst.gnt", gnt, 0);
    check("rst.done", done, 0);
    check("rst.ce", eng_ce, 0);
    check("rst.start", eng_start, 0);
    check("rst.busy", busy, 0);
    check("rst.result", result, 0);
    check("rst.initval", eng_initval, 0);
    check("rst.err", err, 0);
    rst = 1'b0;
    step();
    check("idle.busy", busy, 0);

    // Single request from requester 1.
    req = 4'b0010;
    do_job("single", 4'b0010, 32'hDEADBEEF, 32'h12345678, 5, 4'b0000);

    // All requesters held: strict rotation starting at 0 after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      do_job("rr", 4'(1 << (j % 4)), ivs[j % 4], 32'hA0000000 + 32'(j), 2 + (j % 3),
             (j == 7) ? 4'b0000 : 4'b1111);
    end

    // Pointer at 0: requester 3 must beat requester 0.
    req = 4'b0001;
    do_job("ptr0", 4'b0001, 32'h11111111, 32'h0BADC0DE, 1, 4'b0000);
    req = 4'b1001;
    do_job("wrap3", 4'b1000, 32'h33333333, 32'h00003333, 2, 4'b0001);
    do_job("wrap0", 4'b0001, 32'h11111111, 32'h00000001, 2, 4'b0000);

    // Granted requester drops req mid-run; job still completes.
    req = 4'b0100;
    step();
    check("drop.gnt", gnt, 4'b0100);
    step();
    req = 4'b0000;
    step();
    check("drop.ce1", eng_ce, 4'b0100);
    check("drop.busy", busy, 1);
    check("drop.done_early", done, 0);
    step();
    check("drop.ce2", eng_ce, 4'b0100);
    eng_hash = 32'hCAFEF00D;
    eng_done = 1'b1;
    step();
    check("drop.done", done, 4'b0100);
    check("drop.result", result, 32'hCAFEF00D);
    check("drop.ce_done", eng_ce, 0);
    eng_done = 1'b0;
    step();
    check("drop.idle", busy, 0);

    // Stale eng_done level across IDLE/START/RUN is not a completion.
    eng_done = 1'b1;
    eng_hash = 32'h5A5A5A5A;
    req      = 4'b1000;
    step();
    check("stale.gnt", gnt, 4'b1000);
    step();
    for (int i = 0; i < 3; i++) begin
      check("stale.done", done, 0);
      check("stale.busy", busy, 1);
      check("stale.result", result, 32'hCAFEF00D);
      step();
    end
    eng_done = 1'b0;
    step();
    eng_done = 1'b1;
    step();
    check("stale.done_edge", done, 4'b1000);
    check("stale.result_edge", result, 32'h5A5A5A5A);
    eng_done = 1'b0;
    req      = 4'b0000;
    step();

    // Reset two cycles into S_RUN abandons the job.
    req = 4'b0001;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("midrst.gnt", gnt, 0);
    check("midrst.ce", eng_ce, 0);
    check("midrst.busy", busy, 0);
    check("midrst.result", result, 0);
    check("midrst.done", done, 0);
    rst = 1'b0;
    do_job("restart", 4'b0001, 32'h11111111, 32'h76543210, 3, 4'b0000);

    // Engine never completes.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0011;
    step();
    check("tmo.gnt", gnt, 4'b0001);
    step();
    for (int i = 0; i < 14; i++) begin
      check("tmo.busy", busy, 1);
      step();
    end
    step();
    check("tmo.ce_last", eng_ce, 4'b0001);
    check("tmo.err_pre", err, 0);
`ifdef JHASH_SCHED_TIMEOUT_EN
    step();
    check("tmo.err", err, 4'b0001);
    check("tmo.no_done", done, 0);
    check("tmo.ce_drop", eng_ce, 0);
    check("tmo.result", result, 0);
    step();
    check("tmo.idle", busy, 0);
    step();
    check("tmo.next_gnt", gnt, 4'b0010);
    step();
    eng_hash = 32'h00C0FFEE;
    eng_done = 1'b1;
    step();
    check("tmo.next_done", done, 4'b0010);
    check("tmo.err_sticky", err, 4'b0001);
    eng_done = 1'b0;
    req      = 4'b0000;
    step();
`else
    for (int i = 0; i < 10; i++) begin
      step();
      check("notmo.busy", busy, 1);
      check("notmo.ce", eng_ce, 4'b0001);
      check("notmo.done", done, 0);
      check("notmo.err", err, 0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0000;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
